seg7_scan_ctrl: RTL

Scan scheduler for a multiplexed common-cathode 7-segment display of N hex digits. It time-slices the shared segment bus between digits and inserts a blanking dead-time at every digit change to suppress ghosting. It applies a PWM brightness window and accepts new display values through a valid/ready handshake. New values are committed only at frame boundaries, so a frame never shows a torn value. It replaces free-running digit muxing in the top level, sitting between the value counters and the seg/gnd pins.

---
 rtl/seg7_pkg.sv | 21 ++
 rtl/seg7_hex_dec.sv | 13 +
 rtl/seg7_scan_ctrl.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/seg7_pkg.sv
// Shared types and constants for the 7-segment scan controller and hex decoder.
package seg7_pkg;

  typedef enum logic [1:0] {
    BLANK,
    ON,
    OFF
  } phase_e;

  // Active-high segments packed {a,b,c,d,e,f,g}
  localparam logic [6:0] HEX_SEG [16] = '{
    7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
    7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47
  };

  function automatic int cnt_width(input int n);
    if (n <= 2) return 1;
    return $clog2(n);
  endfunction

endpackage

// File: rtl/seg7_hex_dec.sv
// Combinational hex nibble to 7-segment decoder, shared by display blocks.
module seg7_hex_dec
  import seg7_pkg::*;
(
  input  logic [3:0] nib_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = HEX_SEG[nib_i];
  end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Multiplexed 7-segment scan scheduler with dead-time, PWM brightness and frame-aligned loads.
// Optional leading-zero blanking when SEG7_SCAN_LZB_EN is defined.
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int N        = 4,
  parameter int TICK_DIV = 25000,
  parameter int DEAD     = 500,
  parameter int BW       = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load_valid,
  output logic            load_ready,
  input  logic [4*N-1:0]  load_num,
  input  logic [BW-1:0]   load_bright,
  output logic [6:0]      seg,
  output logic [N-1:0]    dig_en,
  output logic            frame_start
);

  localparam int CW   = cnt_width(TICK_DIV);
  localparam int DW   = cnt_width(N);
  localparam int STEP = (TICK_DIV - DEAD) / ((1 << BW) - 1);
  localparam int PW   = CW + BW;

  if (N < 1 || DEAD >= TICK_DIV || STEP < 1) begin : g_bad_params
    $error("seg7_scan_ctrl: need N>=1, DEAD<TICK_DIV and STEP>=1");
  end

  logic [CW-1:0]   c_q, c_d;
  logic [DW-1:0]   d_q, d_d;
  logic [4*N-1:0]  pend_num_q, pend_num_d;
  logic [BW-1:0]   pend_bright_q, pend_bright_d;
  logic            pend_full_q, pend_full_d;
  logic [4*N-1:0]  disp_num_q, disp_num_d;
  logic [BW-1:0]   disp_bright_q, disp_bright_d;
  logic [6:0]      seg_q, seg_d;
  logic [N-1:0]    dig_en_q, dig_en_d;
  logic            frame_start_q, frame_start_d;

  logic            c_wrap, d_last, boundary, accept, commit;
  logic [PW-1:0]   c_ext, on_end;
  phase_e          phase;
  logic [3:0]      cur_nib;
  logic [6:0]      dec_seg;
  logic            digit_vis;
  logic            show;

  assign c_wrap   = (c_q == CW'(TICK_DIV - 1));
  assign d_last   = (d_q == DW'(N - 1));
  assign boundary = c_wrap & d_last;
  assign accept   = load_valid & ~pend_full_q;
  assign commit   = boundary & pend_full_q;

  always_comb begin
    c_d = c_wrap ? '0 : c_q + CW'(1);
    d_d = d_q;
    if (c_wrap) begin
      d_d = d_last ? '0 : d_q + DW'(1);
    end
  end

  // Pending slot is single-entry; an accept on the boundary cycle is held for the next frame.
  always_comb begin
    pend_num_d    = pend_num_q;
    pend_bright_d = pend_bright_q;
    pend_full_d   = pend_full_q;
    disp_num_d    = disp_num_q;
    disp_bright_d = disp_bright_q;
    if (commit) begin
      disp_num_d    = pend_num_q;
      disp_bright_d = pend_bright_q;
      pend_full_d   = 1'b0;
    end else if (accept) begin
      pend_num_d    = load_num;
      pend_bright_d = load_bright;
      pend_full_d   = 1'b1;
    end
  end

  always_comb begin
    c_ext  = PW'(c_q);
    on_end = PW'(DEAD) + PW'(disp_bright_q) * PW'(STEP);
    if (c_ext < PW'(DEAD)) begin
      phase = BLANK;
    end else if (c_ext < on_end) begin
      phase = ON;
    end else begin
      phase = OFF;
    end
  end

  always_comb begin
    cur_nib = '0;
    for (int i = 0; i < N; i++) begin
      if (d_q == DW'(i)) cur_nib = disp_num_q[4*i +: 4];
    end
  end

`ifdef SEG7_SCAN_LZB_EN
  logic [DW-1:0] msd;

  // Digit 0 is always visible so an all-zero value still reads "0".
  always_comb begin
    msd = '0;
    for (int i = 1; i < N; i++) begin
      if (disp_num_q[4*i +: 4] != 4'd0) msd = DW'(i);
    end
  end

  assign digit_vis = (d_q <= msd);
`else
  assign digit_vis = 1'b1;
`endif

  seg7_hex_dec u_hex_dec (
    .nib_i (cur_nib),
    .seg_o (dec_seg)
  );

  assign show = (phase == ON) & digit_vis;

  always_comb begin
    seg_d         = show ? dec_seg : 7'd0;
    frame_start_d = (c_q == '0) && (d_q == '0);
    for (int i = 0; i < N; i++) begin
      dig_en_d[i] = show && (d_q == DW'(i));
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      c_q           <= '0;
      d_q           <= '0;
      pend_num_q    <= '0;
      pend_bright_q <= '0;
      pend_full_q   <= 1'b0;
      disp_num_q    <= '0;
      disp_bright_q <= '0;
      seg_q         <= '0;
      dig_en_q      <= '0;
      frame_start_q <= 1'b0;
    end else begin
      c_q           <= c_d;
      d_q           <= d_d;
      pend_num_q    <= pend_num_d;
      pend_bright_q <= pend_bright_d;
      pend_full_q   <= pend_full_d;
      disp_num_q    <= disp_num_d;
      disp_bright_q <= disp_bright_d;
      seg_q         <= seg_d;
      dig_en_q      <= dig_en_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign load_ready  = ~pend_full_q;
  assign seg         = seg_q;
  assign dig_en      = dig_en_q;
  assign frame_start = frame_start_q;

endmodule
